// File: rtl/tower_unpack_if.sv
// Link-word and tower-record signal bundle for tower_unpack.
// master = link source plus record sink; slave = the unpacker itself.
interface tower_unpack_if #(
   parameter int FW = 10
);
   logic [31:0]   in_data;
   logic          in_valid;
   logic          in_ready;
   logic          tower_valid;
   logic          tower_ready;
   logic [FW-1:0] tower_et;
   logic [FW-1:0] tower_e;
   logic [FW-1:0] tower_eta;
   logic [FW-1:0] tower_phi;
   logic [FW-1:0] tower_index;
   logic [10:0]   numtowers;
   logic          frame_done;
   logic          err_tag;
   logic          err_count;
   logic          err_sum;
   logic          busy;

   modport master (
      output in_data, in_valid, tower_ready,
      input  in_ready, tower_valid, tower_et, tower_e, tower_eta, tower_phi,
             tower_index, numtowers, frame_done, err_tag, err_count, err_sum, busy
   );

   modport slave (
      input  in_data, in_valid, tower_ready,
      output in_ready, tower_valid, tower_et, tower_e, tower_eta, tower_phi,
             tower_index, numtowers, frame_done, err_tag, err_count, err_sum, busy
   );
endinterface

// File: rtl/tower_unpack.sv
// Deserialises framed 32-bit link words (HDR, A/B pairs, TRL) into per-tower
// records, checking tags, header count and the trailer et checksum.
module tower_unpack #(
   parameter int MAX_TOWERS = 1024,
   parameter int FW         = 10
) (
   input logic           clk,
   input logic           rst,
   tower_unpack_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WA,
      S_WB,
      S_TRL,
      S_RESYNC
   } state_e;

   localparam logic [1:0] TAG_TRL = 2'b00;
   localparam logic [1:0] TAG_HDR = 2'b01;
   localparam logic [1:0] TAG_A   = 2'b10;
   localparam logic [1:0] TAG_B   = 2'b11;

   state_e        state_q, state_d;
   logic [10:0]   numtowers_q, numtowers_d;
   logic [10:0]   idx_q, idx_d;
   logic [15:0]   acc_q, acc_d;
   logic [FW-1:0] a_et_q, a_et_d;
   logic [FW-1:0] a_e_q, a_e_d;
   logic [FW-1:0] a_eta_q, a_eta_d;
   logic [FW-1:0] out_et_q, out_et_d;
   logic [FW-1:0] out_e_q, out_e_d;
   logic [FW-1:0] out_eta_q, out_eta_d;
   logic [FW-1:0] out_phi_q, out_phi_d;
   logic [FW-1:0] out_idx_q, out_idx_d;
   logic          tower_valid_q, tower_valid_d;
   logic          frame_done_q, frame_done_d;
   logic          err_tag_q, err_tag_d;
   logic          err_count_q, err_count_d;
   logic          err_sum_q, err_sum_d;

   logic          in_ready;
   logic          busy;
   logic          xfer;
   logic [1:0]    tag;
   logic [10:0]   hdr_count;
   logic [10:0]   idx_inc;

   assign tag       = bus.in_data[31:30];
   assign hdr_count = bus.in_data[10:0];
   assign idx_inc   = idx_q + 11'd1;
   assign xfer      = bus.in_valid && in_ready;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values; the reset clears the whole datapath, not just state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         numtowers_q   <= '0;
         idx_q         <= '0;
         acc_q         <= '0;
         a_et_q        <= '0;
         a_e_q         <= '0;
         a_eta_q       <= '0;
         out_et_q      <= '0;
         out_e_q       <= '0;
         out_eta_q     <= '0;
         out_phi_q     <= '0;
         out_idx_q     <= '0;
         tower_valid_q <= 1'b0;
         frame_done_q  <= 1'b0;
         err_tag_q     <= 1'b0;
         err_count_q   <= 1'b0;
         err_sum_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         numtowers_q   <= numtowers_d;
         idx_q         <= idx_d;
         acc_q         <= acc_d;
         a_et_q        <= a_et_d;
         a_e_q         <= a_e_d;
         a_eta_q       <= a_eta_d;
         out_et_q      <= out_et_d;
         out_e_q       <= out_e_d;
         out_eta_q     <= out_eta_d;
         out_phi_q     <= out_phi_d;
         out_idx_q     <= out_idx_d;
         tower_valid_q <= tower_valid_d;
         frame_done_q  <= frame_done_d;
         err_tag_q     <= err_tag_d;
         err_count_q   <= err_count_d;
         err_sum_q     <= err_sum_d;
      end
   end

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_d       = state_q;
      numtowers_d   = numtowers_q;
      idx_d         = idx_q;
      acc_d         = acc_q;
      a_et_d        = a_et_q;
      a_e_d         = a_e_q;
      a_eta_d       = a_eta_q;
      out_et_d      = out_et_q;
      out_e_d       = out_e_q;
      out_eta_d     = out_eta_q;
      out_phi_d     = out_phi_q;
      out_idx_d     = out_idx_q;
      tower_valid_d = tower_valid_q && !bus.tower_ready;
      frame_done_d  = 1'b0;
      err_tag_d     = 1'b0;
      err_count_d   = 1'b0;
      err_sum_d     = 1'b0;

      if (xfer) begin
         unique case (state_q)
            S_IDLE, S_RESYNC: begin
               // Both states treat a header identically; everything else is dropped.
               if (tag == TAG_HDR) begin
                  if (hdr_count > 11'(MAX_TOWERS)) begin
                     err_count_d = 1'b1;
                     state_d     = S_RESYNC;
                  end else begin
                     numtowers_d = hdr_count;
                     idx_d       = '0;
                     acc_d       = '0;
                     state_d     = (hdr_count == 11'd0) ? S_TRL : S_WA;
                  end
               end
            end
            S_WA: begin
               if (tag == TAG_A) begin
                  a_et_d  = bus.in_data[20 +: FW];
                  a_e_d   = bus.in_data[10 +: FW];
                  a_eta_d = bus.in_data[0 +: FW];
                  acc_d   = acc_q + 16'(bus.in_data[20 +: FW]);
                  state_d = S_WB;
               end else begin
                  err_tag_d = 1'b1;
                  state_d   = S_RESYNC;
               end
            end
            S_WB: begin
               if (tag == TAG_B) begin
                  out_et_d      = a_et_q;
                  out_e_d       = a_e_q;
                  out_eta_d     = a_eta_q;
                  out_phi_d     = bus.in_data[0 +: FW];
                  out_idx_d     = idx_q[FW-1:0];
                  tower_valid_d = 1'b1;
                  idx_d         = idx_inc;
                  state_d       = (idx_inc < numtowers_q) ? S_WA : S_TRL;
               end else begin
                  err_tag_d = 1'b1;
                  state_d   = S_RESYNC;
               end
            end
            S_TRL: begin
               if (tag == TAG_TRL) begin
                  frame_done_d = 1'b1;
                  err_sum_d    = (bus.in_data[15:0] != acc_q);
                  state_d      = S_IDLE;
               end else begin
                  err_tag_d = 1'b1;
                  state_d   = S_RESYNC;
               end
            end
            default: state_d = S_RESYNC;
         endcase
      end
   end

   // A B word may only land when the output slot is free or draining this cycle.
   always_comb begin
      in_ready = 1'b1;
      if (state_q == S_WB) begin
         in_ready = !tower_valid_q || bus.tower_ready;
      end
      busy = (state_q != S_IDLE);
   end

   assign bus.in_ready    = in_ready;
   assign bus.busy        = busy;
   assign bus.tower_valid = tower_valid_q;
   assign bus.tower_et    = out_et_q;
   assign bus.tower_e     = out_e_q;
   assign bus.tower_eta   = out_eta_q;
   assign bus.tower_phi   = out_phi_q;
   assign bus.tower_index = out_idx_q;
   assign bus.numtowers   = numtowers_q;
   assign bus.frame_done  = frame_done_q;
   assign bus.err_tag     = err_tag_q;
   assign bus.err_count   = err_count_q;
   assign bus.err_sum     = err_sum_q;

endmodule
